// File: rtl/exe_stage_if.sv
// Execute-stage bus interface.
// Carries the ID/EXE inputs of the execute stage (decoded controls, operands,
// immediate, register specifiers, forwarding selects and data, stall/flush)
// and its EXE/MEM outputs (registered controls, ALU result, store data,
// destination register, zero flag, branch resolution, instruction count).
//   slave  : the execute stage itself (consumes *_in, drives *_out)
//   master : whoever feeds the stage and observes its results
interface exe_stage_if;
  logic        reg_write_in;
  logic        mem_to_reg_in;
  logic        mem_write_in;
  logic        mem_read_in;
  logic        alu_src_in;
  logic        reg_dst_in;
  logic        beq_in;
  logic        bne_in;
  logic [2:0]  alu_op_in;
  logic [31:0] pc_plus4_in;
  logic [31:0] read_data1_in;
  logic [31:0] read_data2_in;
  logic [31:0] address_in;
  logic [4:0]  rt_in;
  logic [4:0]  rd_in;
  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
  logic [31:0] mem_fwd_data;
  logic [31:0] wb_fwd_data;
  logic        stall_in;
  logic        flush_in;

  logic        reg_write_out;
  logic        mem_to_reg_out;
  logic        mem_write_out;
  logic        mem_read_out;
  logic [31:0] alu_result_out;
  logic [31:0] write_data_out;
  logic [4:0]  dest_reg_out;
  logic        zero_out;
  logic        branch_taken_out;
  logic [31:0] branch_target_out;
  logic [15:0] inst_count_out;

  modport slave (
    input  reg_write_in, mem_to_reg_in, mem_write_in, mem_read_in,
           alu_src_in, reg_dst_in, beq_in, bne_in, alu_op_in,
           pc_plus4_in, read_data1_in, read_data2_in, address_in,
           rt_in, rd_in, fwd_a_sel, fwd_b_sel, mem_fwd_data, wb_fwd_data,
           stall_in, flush_in,
    output reg_write_out, mem_to_reg_out, mem_write_out, mem_read_out,
           alu_result_out, write_data_out, dest_reg_out, zero_out,
           branch_taken_out, branch_target_out, inst_count_out
  );

  modport master (
    output reg_write_in, mem_to_reg_in, mem_write_in, mem_read_in,
           alu_src_in, reg_dst_in, beq_in, bne_in, alu_op_in,
           pc_plus4_in, read_data1_in, read_data2_in, address_in,
           rt_in, rd_in, fwd_a_sel, fwd_b_sel, mem_fwd_data, wb_fwd_data,
           stall_in, flush_in,
    input  reg_write_out, mem_to_reg_out, mem_write_out, mem_read_out,
           alu_result_out, write_data_out, dest_reg_out, zero_out,
           branch_taken_out, branch_target_out, inst_count_out
  );
endinterface

// File: rtl/exe_stage.sv
// Pipeline execute stage with the EXE/MEM register folded in.
// Selects forwarded operands, runs the ALU, picks the destination register,
// resolves beq/bne and computes the branch target, then registers everything
// with one clock of latency. Also counts captured non-bubble instructions.
// Ports:
//   clk    : clock, all state updates on the rising edge
//   rst    : synchronous, active-low reset
//   bus_io : exe_stage_if.slave carrying all ID/EXE inputs and EXE/MEM outputs
// Edge priority: reset, flush (bubble, counter kept), stall (hold, branch
// pulse cleared), capture.
module exe_stage (
  input  logic            clk,
  input  logic            rst,
  exe_stage_if.slave      bus_io
);

  logic [31:0] opA;
  logic [31:0] fwdB;
  logic [31:0] opB;
  logic [31:0] aluResult;
  logic [4:0]  destReg;
  logic [31:0] branchTarget;
  logic        branchTaken;
  logic        isBubble;

  logic        regWrite_q,     regWrite_d;
  logic        memToReg_q,     memToReg_d;
  logic        memWrite_q,     memWrite_d;
  logic        memRead_q,      memRead_d;
  logic [31:0] aluResult_q,    aluResult_d;
  logic [31:0] writeData_q,    writeData_d;
  logic [4:0]  destReg_q,      destReg_d;
  logic        zero_q,         zero_d;
  logic        branchTaken_q,  branchTaken_d;
  logic [31:0] branchTarget_q, branchTarget_d;
  logic [15:0] instCount_q,    instCount_d;

  // Operand selection; select 11 falls back to the register file value.
  always_comb begin
    unique case (bus_io.fwd_a_sel)
      2'b01:   opA = bus_io.mem_fwd_data;
      2'b10:   opA = bus_io.wb_fwd_data;
      default: opA = bus_io.read_data1_in;
    endcase
    unique case (bus_io.fwd_b_sel)
      2'b01:   fwdB = bus_io.mem_fwd_data;
      2'b10:   fwdB = bus_io.wb_fwd_data;
      default: fwdB = bus_io.read_data2_in;
    endcase
    opB = bus_io.alu_src_in ? bus_io.address_in : fwdB;
  end

  // ALU; add/sub wrap modulo 2^32, slt is a signed compare.
  always_comb begin
    unique case (bus_io.alu_op_in)
      3'b000:  aluResult = opA + opB;
      3'b001:  aluResult = opA - opB;
      3'b010:  aluResult = opA & opB;
      3'b011:  aluResult = opA | opB;
      3'b100:  aluResult = {31'd0, ($signed(opA) < $signed(opB))};
      3'b101:  aluResult = ~(opA | opB);
      3'b110:  aluResult = opA ^ opB;
      default: aluResult = opB;
    endcase
  end

  // Destination, branch resolution and bubble detection. The branch compare
  // always uses the forwarded B operand, never the immediate.
  always_comb begin
    destReg      = bus_io.reg_dst_in ? bus_io.rd_in : bus_io.rt_in;
    branchTarget = bus_io.pc_plus4_in + {bus_io.address_in[29:0], 2'b00};
    branchTaken  = (bus_io.beq_in && (opA == fwdB)) ||
                   (bus_io.bne_in && (opA != fwdB));
    isBubble     = !(bus_io.reg_write_in || bus_io.mem_write_in ||
                     bus_io.mem_read_in  || bus_io.beq_in || bus_io.bne_in);
  end

  // Next-state selection: flush wins over stall and inserts a bubble while
  // keeping the counter; stall holds everything but drops the branch pulse.
  always_comb begin
    regWrite_d     = regWrite_q;
    memToReg_d     = memToReg_q;
    memWrite_d     = memWrite_q;
    memRead_d      = memRead_q;
    aluResult_d    = aluResult_q;
    writeData_d    = writeData_q;
    destReg_d      = destReg_q;
    zero_d         = zero_q;
    branchTaken_d  = branchTaken_q;
    branchTarget_d = branchTarget_q;
    instCount_d    = instCount_q;
    if (bus_io.flush_in) begin
      regWrite_d     = 1'b0;
      memToReg_d     = 1'b0;
      memWrite_d     = 1'b0;
      memRead_d      = 1'b0;
      aluResult_d    = 32'd0;
      writeData_d    = 32'd0;
      destReg_d      = 5'd0;
      zero_d         = 1'b0;
      branchTaken_d  = 1'b0;
      branchTarget_d = 32'd0;
    end else if (bus_io.stall_in) begin
      branchTaken_d  = 1'b0;
    end else begin
      regWrite_d     = bus_io.reg_write_in && (destReg != 5'd0);
      memToReg_d     = bus_io.mem_to_reg_in;
      memWrite_d     = bus_io.mem_write_in;
      memRead_d      = bus_io.mem_read_in;
      aluResult_d    = aluResult;
      writeData_d    = fwdB;
      destReg_d      = destReg;
      zero_d         = (aluResult == 32'd0);
      branchTaken_d  = branchTaken;
      branchTarget_d = branchTarget;
      instCount_d    = isBubble ? instCount_q : instCount_q + 16'd1;
    end
  end

  // EXE/MEM register; reset discards whatever is in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      regWrite_q     <= 1'b0;
      memToReg_q     <= 1'b0;
      memWrite_q     <= 1'b0;
      memRead_q      <= 1'b0;
      aluResult_q    <= 32'd0;
      writeData_q    <= 32'd0;
      destReg_q      <= 5'd0;
      zero_q         <= 1'b0;
      branchTaken_q  <= 1'b0;
      branchTarget_q <= 32'd0;
      instCount_q    <= 16'd0;
    end else begin
      regWrite_q     <= regWrite_d;
      memToReg_q     <= memToReg_d;
      memWrite_q     <= memWrite_d;
      memRead_q      <= memRead_d;
      aluResult_q    <= aluResult_d;
      writeData_q    <= writeData_d;
      destReg_q      <= destReg_d;
      zero_q         <= zero_d;
      branchTaken_q  <= branchTaken_d;
      branchTarget_q <= branchTarget_d;
      instCount_q    <= instCount_d;
    end
  end

  assign bus_io.reg_write_out     = regWrite_q;
  assign bus_io.mem_to_reg_out    = memToReg_q;
  assign bus_io.mem_write_out     = memWrite_q;
  assign bus_io.mem_read_out      = memRead_q;
  assign bus_io.alu_result_out    = aluResult_q;
  assign bus_io.write_data_out    = writeData_q;
  assign bus_io.dest_reg_out      = destReg_q;
  assign bus_io.zero_out          = zero_q;
  assign bus_io.branch_taken_out  = branchTaken_q;
  assign bus_io.branch_target_out = branchTarget_q;
  assign bus_io.inst_count_out    = instCount_q;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed scenarios followed by random
// traffic, all compared against a behavioural model of the stage's outputs.
module tb_exe_stage;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  exe_stage_if bus ();

  exe_stage dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw;
    logic        mtr;
    logic        mw;
    logic        mr;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  dest;
    logic        zero;
    logic        taken;
    logic [31:0] target;
    logic [15:0] count;
  } expOut_t;

  expOut_t model;

  // Expected outputs after capturing the instruction currently on the bus.
  function automatic expOut_t captureModel(expOut_t prev);
    expOut_t e;
    logic [31:0] a, fb, b, r;
    a  = (bus.fwd_a_sel == 2'd1) ? bus.mem_fwd_data :
         (bus.fwd_a_sel == 2'd2) ? bus.wb_fwd_data : bus.read_data1_in;
    fb = (bus.fwd_b_sel == 2'd1) ? bus.mem_fwd_data :
         (bus.fwd_b_sel == 2'd2) ? bus.wb_fwd_data : bus.read_data2_in;
    b  = bus.alu_src_in ? bus.address_in : fb;
    case (bus.alu_op_in)
      3'd0:    r = a + b;
      3'd1:    r = a - b;
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd5:    r = ~(a | b);
      3'd6:    r = a ^ b;
      default: r = b;
    endcase
    e.dest   = bus.reg_dst_in ? bus.rd_in : bus.rt_in;
    e.rw     = bus.reg_write_in && (e.dest != 5'd0);
    e.mtr    = bus.mem_to_reg_in;
    e.mw     = bus.mem_write_in;
    e.mr     = bus.mem_read_in;
    e.alu    = r;
    e.wd     = fb;
    e.zero   = (r == 32'd0);
    e.taken  = (bus.beq_in && a == fb) || (bus.bne_in && a != fb);
    e.target = bus.pc_plus4_in + bus.address_in * 32'd4;
    e.count  = prev.count;
    if (bus.reg_write_in || bus.mem_write_in || bus.mem_read_in ||
        bus.beq_in || bus.bne_in)
      e.count = prev.count + 16'd1;
    return e;
  endfunction

  // Advance the model by the rule in force at this edge, then clock the DUT
  // and settle 1 ns past the edge.
  task automatic applyStimulus();
    logic [15:0] keep;
    if (!rst) begin
      model = '0;
    end else if (bus.flush_in) begin
      keep        = model.count;
      model       = '0;
      model.count = keep;
    end else if (bus.stall_in) begin
      model.taken = 1'b0;
    end else begin
      model = captureModel(model);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".reg_write"},  {31'd0, bus.reg_write_out},    {31'd0, model.rw});
    checkOutput({tag, ".mem_to_reg"}, {31'd0, bus.mem_to_reg_out},   {31'd0, model.mtr});
    checkOutput({tag, ".mem_write"},  {31'd0, bus.mem_write_out},    {31'd0, model.mw});
    checkOutput({tag, ".mem_read"},   {31'd0, bus.mem_read_out},     {31'd0, model.mr});
    checkOutput({tag, ".alu"},        bus.alu_result_out,            model.alu);
    checkOutput({tag, ".wdata"},      bus.write_data_out,            model.wd);
    checkOutput({tag, ".dest"},       {27'd0, bus.dest_reg_out},     {27'd0, model.dest});
    checkOutput({tag, ".zero"},       {31'd0, bus.zero_out},         {31'd0, model.zero});
    checkOutput({tag, ".taken"},      {31'd0, bus.branch_taken_out}, {31'd0, model.taken});
    checkOutput({tag, ".target"},     bus.branch_target_out,         model.target);
    checkOutput({tag, ".count"},      {16'd0, bus.inst_count_out},   {16'd0, model.count});
  endtask

  task automatic clearInputs();
    bus.reg_write_in  = 1'b0;
    bus.mem_to_reg_in = 1'b0;
    bus.mem_write_in  = 1'b0;
    bus.mem_read_in   = 1'b0;
    bus.alu_src_in    = 1'b0;
    bus.reg_dst_in    = 1'b0;
    bus.beq_in        = 1'b0;
    bus.bne_in        = 1'b0;
    bus.alu_op_in     = 3'd0;
    bus.pc_plus4_in   = 32'd0;
    bus.read_data1_in = 32'd0;
    bus.read_data2_in = 32'd0;
    bus.address_in    = 32'd0;
    bus.rt_in         = 5'd0;
    bus.rd_in         = 5'd0;
    bus.fwd_a_sel     = 2'd0;
    bus.fwd_b_sel     = 2'd0;
    bus.mem_fwd_data  = 32'd0;
    bus.wb_fwd_data   = 32'd0;
    bus.stall_in      = 1'b0;
    bus.flush_in      = 1'b0;
  endtask

  task automatic randomInputs();
    bus.reg_write_in  = 1'($urandom);
    bus.mem_to_reg_in = 1'($urandom);
    bus.mem_write_in  = ($urandom_range(0, 3) == 0);
    bus.mem_read_in   = ($urandom_range(0, 3) == 0);
    bus.alu_src_in    = 1'($urandom);
    bus.reg_dst_in    = 1'($urandom);
    bus.beq_in        = ($urandom_range(0, 3) == 0);
    bus.bne_in        = ($urandom_range(0, 3) == 0);
    bus.alu_op_in     = 3'($urandom);
    bus.pc_plus4_in   = $urandom;
    bus.read_data1_in = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
    bus.read_data2_in = ($urandom_range(0, 3) == 0) ? bus.read_data1_in : $urandom;
    bus.address_in    = $urandom;
    bus.rt_in         = 5'($urandom_range(0, 3));
    bus.rd_in         = 5'($urandom);
    bus.fwd_a_sel     = 2'($urandom);
    bus.fwd_b_sel     = 2'($urandom);
    bus.mem_fwd_data  = $urandom;
    bus.wb_fwd_data   = ($urandom_range(0, 3) == 0) ? bus.read_data1_in : $urandom;
    bus.stall_in      = ($urandom_range(0, 4) == 0);
    bus.flush_in      = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    logic [15:0] savedCount;

    // Reset
    rst = 1'b0;
    model = '0;
    clearInputs();
    applyStimulus();
    applyStimulus();
    checkAll("reset");
    checkOutput("reset.count_zero", {16'd0, bus.inst_count_out}, 32'd0);
    rst = 1'b1;

    // add wraps into the sign bit
    bus.alu_op_in     = 3'd0;
    bus.read_data1_in = 32'h7FFF_FFFF;
    bus.read_data2_in = 32'd1;
    bus.reg_write_in  = 1'b1;
    bus.reg_dst_in    = 1'b1;
    bus.rd_in         = 5'd3;
    applyStimulus();
    checkOutput("add.result", bus.alu_result_out, 32'h8000_0000);
    checkOutput("add.zero",   {31'd0, bus.zero_out}, 32'd0);
    checkOutput("add.count",  {16'd0, bus.inst_count_out}, 32'd1);
    checkAll("add");

    // slt signed, then with A forwarded from MEM
    bus.alu_op_in     = 3'd4;
    bus.read_data1_in = 32'hFFFF_FFFF;
    bus.read_data2_in = 32'd1;
    applyStimulus();
    checkOutput("slt.neg", bus.alu_result_out, 32'd1);
    bus.fwd_a_sel     = 2'b01;
    bus.mem_fwd_data  = 32'd5;
    applyStimulus();
    checkOutput("slt.fwd", bus.alu_result_out, 32'd0);
    checkAll("slt");

    // beq taken, then two stall cycles
    clearInputs();
    bus.beq_in        = 1'b1;
    bus.alu_op_in     = 3'd1;
    bus.read_data1_in = 32'd3;
    bus.read_data2_in = 32'd3;
    bus.pc_plus4_in   = 32'h100;
    bus.address_in    = 32'hFFFF_FFFE;
    applyStimulus();
    checkOutput("beq.taken",  {31'd0, bus.branch_taken_out}, 32'd1);
    checkOutput("beq.target", bus.branch_target_out, 32'hF8);
    checkAll("beq");
    bus.stall_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus();
      checkOutput("stall.taken",  {31'd0, bus.branch_taken_out}, 32'd0);
      checkOutput("stall.target", bus.branch_target_out, 32'hF8);
    end
    checkAll("stall");

    // R-type writing r0
    clearInputs();
    savedCount        = bus.inst_count_out;
    bus.reg_write_in  = 1'b1;
    bus.reg_dst_in    = 1'b1;
    bus.rd_in         = 5'd0;
    bus.read_data1_in = 32'd7;
    bus.read_data2_in = 32'd9;
    applyStimulus();
    checkOutput("r0.reg_write", {31'd0, bus.reg_write_out}, 32'd0);
    checkOutput("r0.count", {16'd0, bus.inst_count_out}, {16'd0, savedCount + 16'd1});
    checkAll("r0");

    // sw with stall and flush together
    clearInputs();
    savedCount        = bus.inst_count_out;
    bus.mem_write_in  = 1'b1;
    bus.alu_src_in    = 1'b1;
    bus.address_in    = 32'd16;
    bus.read_data1_in = 32'h1000;
    bus.read_data2_in = 32'hABCD;
    bus.stall_in      = 1'b1;
    bus.flush_in      = 1'b1;
    applyStimulus();
    checkOutput("swflush.mem_write", {31'd0, bus.mem_write_out}, 32'd0);
    checkOutput("swflush.alu", bus.alu_result_out, 32'd0);
    checkOutput("swflush.count", {16'd0, bus.inst_count_out}, {16'd0, savedCount});
    checkAll("swflush");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      randomInputs();
      applyStimulus();
      checkAll("rand");
    end

    // Counter wrap
    clearInputs();
    rst = 1'b0;
    applyStimulus();
    rst = 1'b1;
    bus.reg_write_in = 1'b1;
    bus.reg_dst_in   = 1'b1;
    bus.rd_in        = 5'd1;
    for (int i = 0; i < 65535; i++) applyStimulus();
    checkOutput("wrap.preload", {16'd0, bus.inst_count_out}, 32'h0000_FFFF);
    applyStimulus();
    checkOutput("wrap.zero", {16'd0, bus.inst_count_out}, 32'd0);
    checkAll("wrap");

    // Reset mid-stream with a taken branch in flight
    clearInputs();
    bus.bne_in        = 1'b1;
    bus.reg_write_in  = 1'b1;
    bus.reg_dst_in    = 1'b1;
    bus.rd_in         = 5'd4;
    bus.read_data1_in = 32'd1;
    bus.read_data2_in = 32'd2;
    bus.pc_plus4_in   = 32'h200;
    bus.address_in    = 32'd4;
    bus.stall_in      = 1'b1;
    bus.flush_in      = 1'b1;
    rst               = 1'b0;
    applyStimulus();
    checkOutput("rst.taken", {31'd0, bus.branch_taken_out}, 32'd0);
    checkOutput("rst.count", {16'd0, bus.inst_count_out}, 32'd0);
    checkOutput("rst.target", bus.branch_target_out, 32'd0);
    checkAll("rst");
    rst = 1'b1;
    clearInputs();
    applyStimulus();
    checkAll("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 The module SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have the port rst, input, 1 bit: reset, synchronous and active-low.
REQ-003 The module SHALL have the ports reg_write_in, mem_to_reg_in, mem_write_in, mem_read_in, alu_src_in, reg_dst_in, beq_in and bne_in, inputs, 1 bit each: decoded controls from the ID/EXE register.
REQ-004 The module SHALL have the port alu_op_in, input, 3 bits: ALU operation select.
REQ-005 The module SHALL have the ports pc_plus4_in, read_data1_in, read_data2_in and address_in, inputs, 32 bits each; address_in is the sign-extended immediate.
REQ-006 The module SHALL have the ports rt_in and rd_in, inputs, 5 bits each: register specifiers.
REQ-007 The module SHALL have the ports fwd_a_sel and fwd_b_sel, inputs, 2 bits each: forwarding selects, where 00 is the register file, 01 is mem_fwd_data, 10 is wb_fwd_data and 11 is treated as 00.
REQ-008 The module SHALL have the ports mem_fwd_data and wb_fwd_data, inputs, 32 bits each: forwarded results.
REQ-009 The module SHALL have the ports stall_in and flush_in, inputs, 1 bit each: hold the outputs, or capture a bubble.
REQ-010 The module SHALL have the ports reg_write_out, mem_to_reg_out, mem_write_out and mem_read_out, outputs, 1 bit each: registered controls to the MEM stage.
REQ-011 The module SHALL have the ports alu_result_out and write_data_out, outputs, 32 bits each: the registered ALU result and the forwarded B operand (store data).
REQ-012 The module SHALL have the port dest_reg_out, output, 5 bits: the registered destination register.
REQ-013 The module SHALL have the port zero_out, output, 1 bit: registered flag, high when the ALU result is 0.
REQ-014 The module SHALL have the ports branch_taken_out (1 bit) and branch_target_out (32 bits), outputs: the registered branch resolution.
REQ-015 The module SHALL have the port inst_count_out, output, 16 bits: count of non-bubble instructions captured.

Function
REQ-016 Operand A SHALL be the value selected by fwd_a_sel; forwarded B (fB) SHALL be the value selected by fwd_b_sel.
REQ-017 Operand B SHALL be address_in when alu_src_in=1, otherwise fB.
REQ-018 The ALU SHALL implement: 000 add, 001 sub, 010 and, 011 or, 100 signed slt (result 1 or 0), 101 nor, 110 xor, 111 pass-B.
REQ-019 Add and sub SHALL be modulo 2^32 with no overflow flag.
REQ-020 The destination register SHALL be rd_in when reg_dst_in=1, otherwise rt_in.
REQ-021 When the destination register is 0, reg_write_out SHALL be forced to 0.
REQ-022 The branch target SHALL be pc_plus4_in + (address_in << 2), modulo 2^32.
REQ-023 The branch condition SHALL be (beq_in AND A==fB) OR (bne_in AND A!=fB), using fB regardless of alu_src_in.
REQ-024 The latency from a given set of inputs to the corresponding outputs SHALL be exactly one clock.
REQ-025 Each clock edge SHALL apply the first matching rule, in priority order: reset, then flush, then stall, then capture.
REQ-026 On flush_in=1, all control outputs and branch_taken_out SHALL be loaded with 0, all data outputs SHALL be loaded with 0, and the counter SHALL be unchanged.
REQ-027 On stall_in=1 with flush_in=0, all outputs SHALL hold their values except branch_taken_out, which SHALL be cleared to 0.
REQ-028 On capture, all outputs SHALL be loaded from the current inputs and computed values.
REQ-029 branch_taken_out SHALL therefore be a one-cycle pulse for each captured taken branch.
REQ-030 A bubble SHALL be an instruction where reg_write_in, mem_write_in, mem_read_in, beq_in and bne_in are all 0.
REQ-031 inst_count_out SHALL increment by 1 on each capture of a non-bubble instruction and SHALL wrap from 0xFFFF to 0x0000.
REQ-032 A flush and a stall in the same cycle SHALL produce a bubble.
REQ-033 Wrong-path squashing after a taken branch is the hazard unit's duty via flush_in; the module SHALL NOT self-flush.

Reset
REQ-034 On a clock edge with rst=0, every output, including inst_count_out, SHALL be loaded with 0, overriding stall_in and flush_in.
REQ-035 An instruction in flight when reset is applied SHALL be discarded, and its branch SHALL NOT be reported.

Verification
REQ-036 The bench SHALL drive add with A=0x7FFFFFFF, B=1, fwd sel 00, capture -> the next cycle shows alu_result_out=0x80000000, zero_out=0, inst_count_out=1.
REQ-037 The bench SHALL drive slt with A=0xFFFFFFFF, B=1 -> alu_result_out=1; with fwd_a_sel=01 and mem_fwd_data=5 -> alu_result_out=0.
REQ-038 The bench SHALL drive beq with A=fB=3, pc_plus4=0x100, imm=0xFFFFFFFE -> branch_taken_out=1 for one cycle and branch_target_out=0xF8; then stall 2 cycles -> taken=0, target held.
REQ-039 The bench SHALL drive an R-type with rd=0 and reg_write_in=1 -> reg_write_out=0, and the counter still increments.
REQ-040 The bench SHALL drive a sw with stall_in=1 and flush_in=1 together -> mem_write_out=0, all outputs 0, counter unchanged.
REQ-041 The bench SHALL preload the counter to 0xFFFF via 65535 captures, then capture one more non-bubble -> inst_count_out=0x0000; then assert rst=0 mid-stream -> all outputs 0 on the next edge.
